l15_mem_responder: RTL
======================

# l15_mem_responder

Synthesizable, parametrised L1.5-side responder model that terminates the core's OpenPiton transducer port in simulation and FPGA bring-up. Accepts load/store requests, services them from an internal word memory, and returns responses after a programmable latency with several requests outstanding. Also issues the post-reset wake-up and on-demand interrupt returns. Sits directly on the core's transducer pins in place of a real L1.5.

## Interface
- `MEM_WORDS`, 1024: 32-bit words of backing memory, power of two; index = `address[2 +: $clog2(MEM_WORDS)]`, upper address bits ignored.
- `DEPTH`, 4: outstanding-request queue depth, power of two, ≥2.
- `LATENCY`, 2: minimum cycles from accept edge to response `val`, 1..15.
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `transducer_l15_rqtype` in 5: request type (LOAD_RQ=0, STORE_RQ=1).
- `transducer_l15_size` in 3: 0B/4B=word, 1B=byte, 2B=half.
- `transducer_l15_address` in 32: byte address.
- `transducer_l15_data` in 64: store data, payload in bits [31:0], byte 0 at [7:0].
- `transducer_l15_val` in 1: request valid.
- `l15_transducer_ack` out 1: request accepted this cycle.
- `l15_transducer_header_ack` out 1: identical to `l15_transducer_ack`.
- `l15_transducer_val` out 1: response valid.
- `l15_transducer_data_0` out 64: response data lanes 0/1.
- `l15_transducer_data_1` out 64: response data lanes 2/3.
- `l15_transducer_returntype` out 4: LOAD_RET=0, ST_ACK=4, INT_RET=7.
- `transducer_l15_req_ack` in 1: core consumed response.
- `irq_req` in 1: one-cycle pulse requesting an INT_RET.
- `outstanding` out $clog2(DEPTH)+1: queue occupancy.

## Operation
- Accept: `ack = header_ack = val && !full`, combinational. On accept edge: entry {type, size, addr, load word, age=0} pushed.
- Store: memory written on accept edge, byte lanes from `address[1:0]` and size (byte: 1 lane; half: lanes addr[1]*2..+1; word: all, addr[1:0] ignored).
- Load: aligned 32-bit word captured on accept edge, so later stores never affect earlier loads.
- Unsupported rqtype: acked, no memory effect, no queue entry, no response.
- Ages increment each cycle, saturate at 15. Head is ready when age ≥ LATENCY-1 (`val` visible LATENCY cycles after accept edge).
- Response: ready head drives `val`=1 and returntype per type. Load data byte-swapped ({b0,b1,b2,b3}) into lane `address[3:2]` (0=data_0[63:32], 1=data_0[31:0], 2=data_1[63:32], 3=data_1[31:0]); other lanes 0. Store: data all zero.
- `val` and payload stable until `req_ack` sampled high on a clock edge; then pop; next head may respond the following cycle (no gap required beyond the ack edge).
- Interrupt: `irq_req` sets sticky `irq_pend` (multiple pulses merge). Issued only when no response is being driven and head is not ready; returntype 7, data 0, held until `req_ack`. Load/store responses take priority.
- Wake-up: `irq_pend` set by reset release, so first response after reset is INT_RET.
- Simultaneous push and pop: occupancy unchanged, full recomputed same cycle.

## Timing
- Reset values: `ack`=0 (val-gated), `val`=0, data 0, returntype 0, `outstanding`=0; queue empty, `irq_pend`=1. Memory not reset.
- Reset mid-operation: queue and in-flight response dropped immediately; wake-up reissued after release.
- Full: `ack`=0 while occupancy = DEPTH; acceptance resumes the cycle after a pop edge (same cycle if pop and val coincide is not allowed; ack uses registered full).
- Request-to-response: exactly LATENCY cycles when queue empty and output idle.

## Structure
- Package `pkg_l15`: rqtype/returntype/size constants (replacing local defines), `t_l15_entry` struct.
- Sub-module `l15_resp_fifo`: parametrised DEPTH FIFO of `t_l15_entry` with per-entry age counters and occupancy.

## Test plan
- Reset release, `req_ack` tied 1 -> one-cycle `val` with returntype 7 on the first cycle after wake-up issue; `outstanding`=0.
- Store word 0xDEADBEEF @0x10, then load @0x10 (LATENCY=2) -> ST_ACK then LOAD_RET, data_0[63:32]=0xEFBEADDE.
- Store byte 0x5A @0x13 over 0x11223344, load @0x10 -> word 0x5A223344 in memory, returned byte-swapped in lane 0 of data_1? no: lane 0 -> data_0[63:32]=0x4433225A.
- DEPTH=4, hold `req_ack`=0, issue 6 loads -> 4 acked, `ack`=0 for the rest, `outstanding`=4; release `req_ack` -> responses in order.
- `irq_req` pulse while load queued -> LOAD_RET first, then INT_RET.
- Reset asserted with 3 outstanding -> `val`=0 immediately, `outstanding`=0, INT_RET after release.

Source files
------------

// File: rtl/l15_mem_responder_pkg.sv
// Shared types and constants for the L1.5 memory responder model.
package pkg_l15;

  // Request types seen on the transducer port.
  localparam logic [4:0] LOAD_RQ  = 5'd0;
  localparam logic [4:0] STORE_RQ = 5'd1;

  // Response return types driven back to the transducer.
  localparam logic [3:0] LOAD_RET = 4'd0;
  localparam logic [3:0] ST_ACK   = 4'd4;
  localparam logic [3:0] INT_RET  = 4'd7;

  // Request sizes; any other encoding is treated as a full word.
  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;

  // Saturation value of the per-entry age counters.
  localparam logic [3:0] AGE_MAX = 4'd15;

  // One queued request; ldata holds the word captured at accept time.
  typedef struct packed {
    logic [4:0]  rqtype;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] ldata;
  } t_l15_entry;

  // Response output state; exported on the debug port.
  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_RESP = 2'd1,
    OUT_INT  = 2'd2
  } t_out_state;

  // Memory holds byte 0 at [7:0]; the core expects byte 0 in the MSBs.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] ofs);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << ofs;
      SIZE_HALF: be = ofs[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store payload replicated so the enabled lanes pick the right bytes.
  function automatic logic [31:0] store_wdata(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SIZE_BYTE: w = {4{d[7:0]}};
      SIZE_HALF: w = {2{d[15:0]}};
      default:   w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/l15_mem_responder_if.sv
// Transducer <-> L1.5 pin bundle.
//
// Handshakes:
//  - Request: the core holds transducer_l15_val with a stable request; the
//    request is taken on any rising edge where l15_transducer_ack is high
//    (header_ack is the same signal).
//  - Response: l15_transducer_val and its payload stay stable until a rising
//    edge where transducer_l15_req_ack is high; that edge consumes it.
interface l15_mem_responder_if;
  import pkg_l15::*;

  logic [4:0]  transducer_l15_rqtype;
  logic [2:0]  transducer_l15_size;
  logic [31:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic        transducer_l15_val;
  logic        l15_transducer_ack;
  logic        l15_transducer_header_ack;

  logic        l15_transducer_val;
  logic [63:0] l15_transducer_data_0;
  logic [63:0] l15_transducer_data_1;
  logic [3:0]  l15_transducer_returntype;
  logic        transducer_l15_req_ack;

  // Core side.
  modport master (
    output transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
           transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
    input  l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype
  );

  // Responder side.
  modport slave (
    input  transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
           transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
    output l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype
  );
endinterface

// File: rtl/l15_mem_responder_resp_fifo.sv
// Outstanding-request queue with per-entry age counters. An entry becomes
// ready once its age reaches LATENCY-1, so a registered output stage sees it
// exactly LATENCY cycles after the accept edge.
module l15_resp_fifo
  import pkg_l15::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push_i,
  input  t_l15_entry               push_entry_i,
  input  logic                     pop_i,
  output t_l15_entry               head_o,
  output logic                     head_ready_o,
  output logic                     next_ready_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] READY_AGE = 4'(LATENCY - 1);

  t_l15_entry       entries_q [DEPTH];
  t_l15_entry       entries_d [DEPTH];
  logic [3:0]       ages_q    [DEPTH];
  logic [3:0]       ages_d    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_next;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = entries_q[rd_ptr_q];
  assign rd_next = rd_ptr_q + PTR_W'(1);
  assign head_ready_o = (count_q != '0) && (ages_q[rd_ptr_q] >= READY_AGE);
  assign next_ready_o = (count_q > CNT_W'(1)) && (ages_q[rd_next] >= READY_AGE);

  // Next-state for pointers, occupancy, stored entries and ages.
  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      ages_d[i]    = (ages_q[i] == AGE_MAX) ? AGE_MAX : ages_q[i] + 4'd1;
    end
    if (push_ok) begin
      entries_d[wr_ptr_q] = push_entry_i;
      ages_d[wr_ptr_q]    = 4'd0;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_next;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
        ages_q[i]    <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
        ages_q[i]    <= ages_d[i];
      end
    end
  end

endmodule

// File: rtl/l15_mem_responder.sv
// L1.5-side responder: backs the transducer port with a word memory, queues
// load/store responses with a minimum latency, and issues wake-up and
// requested interrupt returns.
module l15_mem_responder
  import pkg_l15::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int DEPTH     = 4,
  parameter int LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   nrst,
  l15_mem_responder_if.slave     bus,
  input  logic                   irq_req,
  output logic [$clog2(DEPTH):0] outstanding,
  output t_out_state             dbg_state
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0]      mem_q [MEM_WORDS];
  logic [IDX_W-1:0] mem_idx;
  logic             accept, push, store_acc;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  t_l15_entry       push_entry, head;
  logic             head_ready, next_ready, fifo_full, pop;
  t_out_state       state_q, state_d;
  logic             irq_pend_q, irq_pend_d;
  logic [31:0]      swapped;
  logic             unused_bits;

  // Full is a registered flag, so ack never depends on a same-cycle pop.
  assign accept    = bus.transducer_l15_val && !fifo_full;
  assign bus.l15_transducer_ack        = accept;
  assign bus.l15_transducer_header_ack = accept;

  assign push      = accept && ((bus.transducer_l15_rqtype == LOAD_RQ) ||
                                (bus.transducer_l15_rqtype == STORE_RQ));
  assign store_acc = accept && (bus.transducer_l15_rqtype == STORE_RQ);
  assign mem_idx   = bus.transducer_l15_address[2 +: IDX_W];
  assign wr_be     = store_be(bus.transducer_l15_size, bus.transducer_l15_address[1:0]);
  assign wr_data   = store_wdata(bus.transducer_l15_size, bus.transducer_l15_data[31:0]);

  // The load word is captured now, so later stores cannot alter it.
  assign push_entry = '{rqtype: bus.transducer_l15_rqtype,
                        size:   bus.transducer_l15_size,
                        addr:   bus.transducer_l15_address,
                        ldata:  mem_q[mem_idx]};

  assign dbg_state = state_q;
  assign unused_bits = ^{bus.transducer_l15_address, bus.transducer_l15_data[63:32],
                         head.size, head.addr};

  // Backing memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (store_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  l15_resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk          (clk),
    .nrst         (nrst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .head_ready_o (head_ready),
    .next_ready_o (next_ready),
    .full_o       (fifo_full),
    .count_o      (outstanding)
  );

  // Output FSM: queued responses win; interrupts fill idle gaps only.
  always_comb begin
    state_d    = state_q;
    irq_pend_d = irq_pend_q | irq_req;
    pop        = 1'b0;
    case (state_q)
      OUT_IDLE: begin
        if (head_ready) begin
          state_d = OUT_RESP;
        end else if (irq_pend_q) begin
          state_d    = OUT_INT;
          irq_pend_d = irq_req;
        end
      end
      OUT_RESP: begin
        if (bus.transducer_l15_req_ack) begin
          pop = 1'b1;
          if (next_ready) begin
            state_d = OUT_RESP;
          end else if (irq_pend_q) begin
            state_d    = OUT_INT;
            irq_pend_d = irq_req;
          end else begin
            state_d = OUT_IDLE;
          end
        end
      end
      OUT_INT: begin
        if (bus.transducer_l15_req_ack) begin
          if (head_ready) begin
            state_d = OUT_RESP;
          end else if (irq_pend_q) begin
            state_d    = OUT_INT;
            irq_pend_d = irq_req;
          end else begin
            state_d = OUT_IDLE;
          end
        end
      end
      default: state_d = OUT_IDLE;
    endcase
  end

  // Response payload decoded from the output state and queue head.
  always_comb begin
    bus.l15_transducer_val        = 1'b0;
    bus.l15_transducer_returntype = LOAD_RET;
    bus.l15_transducer_data_0     = '0;
    bus.l15_transducer_data_1     = '0;
    swapped                       = byte_swap32(head.ldata);
    case (state_q)
      OUT_RESP: begin
        bus.l15_transducer_val = 1'b1;
        if (head.rqtype == STORE_RQ) begin
          bus.l15_transducer_returntype = ST_ACK;
        end else begin
          bus.l15_transducer_returntype = LOAD_RET;
          case (head.addr[3:2])
            2'd0:    bus.l15_transducer_data_0 = {swapped, 32'h0};
            2'd1:    bus.l15_transducer_data_0 = {32'h0, swapped};
            2'd2:    bus.l15_transducer_data_1 = {swapped, 32'h0};
            default: bus.l15_transducer_data_1 = {32'h0, swapped};
          endcase
        end
      end
      OUT_INT: begin
        bus.l15_transducer_val        = 1'b1;
        bus.l15_transducer_returntype = INT_RET;
      end
      default: ;
    endcase
  end

  // Output state and interrupt pending; reset arms the wake-up interrupt.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= OUT_IDLE;
      irq_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
    end
  end

endmodule
